// File: rtl/porta_ioc_port.sv
// porta_ioc_port: synchronised, debounced input port at file address 7'h05; interrupt-on-change regs when PORTA_IOC_EN is defined.
// Latency: pin -> PORTA worst case 2 + DEB_SAMPLES*TICK_DIV clk; register reads are combinational from addr.
// No backpressure: writes are always accepted in their strobe cycle, reads are always valid.
module porta_ioc_port #(
   parameter int WIDTH       = 8,
   parameter int TICK_DIV    = 16,
   parameter int DEB_SAMPLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [6:0]       addr,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   output logic [7:0]       rd_data,
   output logic             rd_hit,
   output logic             ioc_irq
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [6:0] ADDR_PORTA = 7'h05;
   localparam logic [6:0] ADDR_IOCAP = 7'h11;
   localparam logic [6:0] ADDR_IOCAN = 7'h12;
   localparam logic [6:0] ADDR_IOCAF = 7'h13;

   logic [WIDTH-1:0]                  sync1;
   logic [WIDTH-1:0]                  sync_s;
   logic [CW-1:0]                     tick_cnt;
   logic                              tick;
   logic [WIDTH-1:0][DEB_SAMPLES-1:0] hist;
   logic [WIDTH-1:0][DEB_SAMPLES-1:0] hist_nxt;
   logic [WIDTH-1:0]                  porta;
   logic [WIDTH-1:0]                  porta_nxt;

   assign tick = (tick_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync_s   <= '0;
         tick_cnt <= '0;
      end else begin
         sync1    <= pin_in;
         sync_s   <= sync1;
         tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      end
   end

   // A level is accepted only once the whole sample window agrees; mixed windows hold PORTA.
   always_comb begin
      hist_nxt  = hist;
      porta_nxt = porta;
      if (tick) begin
         for (int i = 0; i < WIDTH; i++) begin
            hist_nxt[i] = {hist[i][DEB_SAMPLES-2:0], sync_s[i]};
            if (&hist_nxt[i])
               porta_nxt[i] = 1'b1;
            else if (~|hist_nxt[i])
               porta_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist  <= '0;
         porta <= '0;
      end else begin
         hist  <= hist_nxt;
         porta <= porta_nxt;
      end
   end

`ifdef PORTA_IOC_EN
   logic [WIDTH-1:0] iocap;
   logic [WIDTH-1:0] iocan;
   logic [WIDTH-1:0] iocaf;
   logic [WIDTH-1:0] ioc_set;

   // Edges are taken from the PORTA update itself, so enables are the pre-write values.
   assign ioc_set = (~porta & porta_nxt & iocap) | (porta & ~porta_nxt & iocan);

   always_ff @(posedge clk) begin
      if (rst) begin
         iocap <= '0;
         iocan <= '0;
         iocaf <= '0;
      end else begin
         if (wr_en && addr == ADDR_IOCAP)
            iocap <= wr_data[WIDTH-1:0];
         if (wr_en && addr == ADDR_IOCAN)
            iocan <= wr_data[WIDTH-1:0];
         if (wr_en && addr == ADDR_IOCAF)
            iocaf <= (iocaf & wr_data[WIDTH-1:0]) | ioc_set;
         else
            iocaf <= iocaf | ioc_set;
      end
   end

   assign ioc_irq = |iocaf;
`else
   assign ioc_irq = 1'b0;
`endif

   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_data};

   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
      case (addr)
         ADDR_PORTA: begin
            rd_hit              = 1'b1;
            rd_data[WIDTH-1:0]  = porta;
         end
`ifdef PORTA_IOC_EN
         ADDR_IOCAP: begin
            rd_hit              = 1'b1;
            rd_data[WIDTH-1:0]  = iocap;
         end
         ADDR_IOCAN: begin
            rd_hit              = 1'b1;
            rd_data[WIDTH-1:0]  = iocan;
         end
         ADDR_IOCAF: begin
            rd_hit              = 1'b1;
            rd_data[WIDTH-1:0]  = iocaf;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_porta_ioc_port.sv
// Bench for porta_ioc_port: queue-based model of sync/debounce/IOC checked every cycle, plus directed literal checks.
module tb_porta_ioc_port;
   localparam int WIDTH = 8;
   localparam int TICK_DIV = 4;
   localparam int DEB = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pin_in;
   logic [6:0] addr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       rd_hit;
   logic       ioc_irq;

   int n_chk = 0;
   int n_pass = 0;

   porta_ioc_port #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DEB_SAMPLES(DEB)) dut (
      .clk(clk), .rst(rst), .pin_in(pin_in), .addr(addr), .wr_en(wr_en),
      .wr_data(wr_data), .rd_data(rd_data), .rd_hit(rd_hit), .ioc_irq(ioc_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: pins seen two clocks late, sampled every TICK_DIV-th clock, level accepted when the last DEB samples agree.
   logic [7:0] m_porta = '0, m_iocap = '0, m_iocan = '0, m_iocaf = '0;
   int         m_k = 0;
   logic [7:0] m_pinq[$];
   logic [7:0] m_samp[$];

   always @(posedge clk) begin
      logic [7:0] s, old, setv;
      int ones;
      if (rst) begin
         m_porta = '0; m_iocap = '0; m_iocan = '0; m_iocaf = '0;
         m_k = 0;
         m_pinq = {8'h00, 8'h00};
         m_samp = {8'h00, 8'h00, 8'h00};
      end else begin
         s = m_pinq.pop_front();
         m_pinq.push_back(pin_in);
         old = m_porta;
         if (m_k % TICK_DIV == TICK_DIV - 1) begin
            m_samp.push_back(s);
            void'(m_samp.pop_front());
            for (int b = 0; b < 8; b++) begin
               ones = 0;
               foreach (m_samp[j]) ones += m_samp[j][b];
               if (ones == DEB) m_porta[b] = 1'b1;
               else if (ones == 0) m_porta[b] = 1'b0;
            end
         end
         m_k++;
         setv = (~old & m_porta & m_iocap) | (old & ~m_porta & m_iocan);
`ifdef PORTA_IOC_EN
         if (wr_en && addr == 7'h13) m_iocaf = (m_iocaf & wr_data) | setv;
         else m_iocaf = m_iocaf | setv;
         if (wr_en && addr == 7'h11) m_iocap = wr_data;
         if (wr_en && addr == 7'h12) m_iocan = wr_data;
`else
         if (setv != 8'h00 && wr_en) m_iocaf = '0;
`endif
      end
   end

   function automatic void exp_read(input logic [6:0] a, output logic h, output logic [7:0] d);
      h = 1'b0;
      d = 8'h00;
      case (a)
         7'h05: begin h = 1'b1; d = m_porta; end
`ifdef PORTA_IOC_EN
         7'h11: begin h = 1'b1; d = m_iocap; end
         7'h12: begin h = 1'b1; d = m_iocan; end
         7'h13: begin h = 1'b1; d = m_iocaf; end
`endif
         default: ;
      endcase
   endfunction

   always @(posedge clk) begin
      logic       eh;
      logic [7:0] ed;
      #1;
      exp_read(addr, eh, ed);
      check("cyc_rd_hit", {31'b0, rd_hit}, {31'b0, eh});
      check("cyc_rd_data", {24'b0, rd_data}, {24'b0, ed});
      check("cyc_ioc_irq", {31'b0, ioc_irq}, {31'b0, |m_iocaf});
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reg_write(input logic [6:0] a, input logic [7:0] d);
      addr = a; wr_data = d; wr_en = 1'b1;
      step(1);
      wr_en = 1'b0;
      addr = 7'h05;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit found;
      rst = 1'b1; pin_in = 8'hFF; addr = 7'h05; wr_en = 1'b0; wr_data = 8'h00;

      // Reset state with pins high
      step(2);
      addr = 7'h11; #1 check("rst_iocap", {24'b0, rd_data}, 32'h0);
      addr = 7'h12; #1 check("rst_iocan", {24'b0, rd_data}, 32'h0);
      addr = 7'h13; #1 check("rst_iocaf", {24'b0, rd_data}, 32'h0);
      addr = 7'h05; #1 check("rst_porta", {24'b0, rd_data}, 32'h0);
      check("rst_irq", {31'b0, ioc_irq}, 32'h0);
      rst = 1'b0;

      // PORTA must not change before the third tick, and must follow by the 12th clock
      step(11);
      check("porta_before_3rd_tick", {24'b0, rd_data}, 32'h00);
      step(1);
      check("porta_after_3rd_tick", {24'b0, rd_data}, 32'hFF);

      // Glitch rejection then stable acceptance
      pin_in = 8'h00; step(20);
      check("porta_all_low", {24'b0, rd_data}, 32'h00);
      pin_in = 8'h01; step(5); pin_in = 8'h00; step(20);
      check("porta_glitch_rejected", {24'b0, rd_data}, 32'h00);
      pin_in = 8'h01; step(16);
      check("porta_bit0_accepted", {24'b0, rd_data}, 32'h01);

`ifdef PORTA_IOC_EN
      // Rising-edge flag coincides with PORTA update
      reg_write(7'h11, 8'h01);
      pin_in = 8'h00; step(16);
      check("porta_low_again", {24'b0, rd_data}, 32'h00);
      check("no_flag_on_fall", {31'b0, ioc_irq}, 32'h0);
      pin_in = 8'h01;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         if (rd_data[0]) begin
            found = 1'b1;
            check("irq_with_porta_rise", {31'b0, ioc_irq}, 32'h1);
         end
      end
      check("porta0_rise_seen", {31'b0, found}, 32'h1);
      addr = 7'h13; #1 check("iocaf_rise", {24'b0, rd_data}, 32'h01);
      reg_write(7'h13, 8'hFE);
      addr = 7'h13; #1 check("iocaf_cleared", {24'b0, rd_data}, 32'h00);
      check("irq_cleared", {31'b0, ioc_irq}, 32'h0);

      // Falling-edge flag survives a clear-write in the same cycle
      addr = 7'h05;
      reg_write(7'h12, 8'h80);
      pin_in = 8'h81; step(16);
      check("porta_81", {24'b0, rd_data}, 32'h81);
      check("no_flag_rise7", {31'b0, ioc_irq}, 32'h0);
      pin_in = 8'h01;
      addr = 7'h13; wr_data = 8'h00; wr_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         if (rd_data[7]) found = 1'b1;
      end
      wr_en = 1'b0;
      check("set_wins_over_clear", {31'b0, found}, 32'h1);
      step(1);
      check("iocaf7_held", {24'b0, rd_data}, 32'h80);
      check("irq_held", {31'b0, ioc_irq}, 32'h1);
      reg_write(7'h13, 8'h00);
      #1 check("irq_after_clear", {31'b0, ioc_irq}, 32'h0);
`else
      // Without IOC: no extra registers decode and irq stays low
      addr = 7'h13; #1 check("noioc_13_miss", {31'b0, rd_hit}, 32'h0);
      addr = 7'h05;
      reg_write(7'h11, 8'hFF);
      reg_write(7'h12, 8'hFF);
      reg_write(7'h13, 8'hFF);
      pin_in = 8'hFE; step(20);
      check("noioc_porta_fe", {24'b0, rd_data}, 32'hFE);
      pin_in = 8'h01; step(20);
      check("noioc_irq_low", {31'b0, ioc_irq}, 32'h0);
`endif

      // Undecoded addresses and read-only PORTA
      addr = 7'h0D; #1;
      check("portb_miss_hit", {31'b0, rd_hit}, 32'h0);
      check("portb_miss_data", {24'b0, rd_data}, 32'h0);
      addr = 7'h20; #1;
      check("addr20_miss_hit", {31'b0, rd_hit}, 32'h0);
      check("addr20_miss_data", {24'b0, rd_data}, 32'h0);
      reg_write(7'h05, 8'hAA);
      #1 check("porta_ro", {24'b0, rd_data}, 32'h01);

      step(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
